// File: rtl/jelly2_wishbone_console_pkg.sv
// ----------------------------------------------------------------------------
//  jelly2_wishbone_console_pkg
//  Register map, bit positions and state encoding for the console responder.
//  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package jelly2_wishbone_console_pkg;

   localparam logic [1:0] REG_TX_DATA = 2'd0;
   localparam logic [1:0] REG_STATUS  = 2'd1;
   localparam logic [1:0] REG_CONTROL = 2'd2;

   localparam int STATUS_EMPTY_BIT   = 16;
   localparam int STATUS_FULL_BIT    = 17;

   localparam int CONTROL_ENABLE_BIT = 0;
   localparam int CONTROL_FLUSH_BIT  = 1;

   localparam int WAIT_CNT_WIDTH     = 4;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_WAIT   = 2'd1;
   localparam logic [1:0] ST_COMMIT = 2'd2;

endpackage

`default_nettype wire

// File: rtl/jelly2_wishbone_console_fifo.sv
// ----------------------------------------------------------------------------
//  jelly2_wishbone_console_fifo
//  First-word-fall-through byte FIFO with clock enable and flush.
//  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module jelly2_wishbone_console_fifo #(
   parameter int PTR_WIDTH  = 4,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  reset,
   input  logic                  clk,
   input  logic                  cke,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   input  logic                  flush,
   output logic [DATA_WIDTH-1:0] head,
   output logic [PTR_WIDTH:0]    count,
   output logic                  empty,
   output logic                  full
);

   localparam int                   DEPTH   = 2 ** PTR_WIDTH;
   localparam logic [PTR_WIDTH-1:0] PTR_ONE = PTR_WIDTH'(1);
   localparam logic [PTR_WIDTH:0]   CNT_MAX = (PTR_WIDTH + 1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PTR_WIDTH-1:0]  wr_ptr;
   logic [PTR_WIDTH-1:0]  rd_ptr;
   logic                  do_push;
   logic                  do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_MAX);
   assign do_push = push & ~full & ~flush;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (cke) begin
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            count <= count + (PTR_WIDTH + 1)'(do_push) - (PTR_WIDTH + 1)'(do_pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (cke && do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

endmodule

`default_nettype wire

// File: rtl/jelly2_wishbone_console_responder.sv
// ----------------------------------------------------------------------------
//  jelly2_wishbone_console_responder
//  Wishbone classic slave with programmable wait states feeding a console stream.
//  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module jelly2_wishbone_console_responder
   import jelly2_wishbone_console_pkg::*;
#(
   parameter int   WB_ADR_WIDTH   = 24,
   parameter int   WB_DAT_WIDTH   = 32,
   parameter int   WB_SEL_WIDTH   = WB_DAT_WIDTH / 8,
   parameter int   FIFO_PTR_WIDTH = 4,
   parameter int   WAIT_CYCLES    = 1,
   parameter logic INIT_ENABLE    = 1'b1
) (
   input  logic                      reset,
   input  logic                      clk,
   input  logic                      cke,

   input  logic [WB_ADR_WIDTH-1:0]   s_wb_adr_i,
   output logic [WB_DAT_WIDTH-1:0]   s_wb_dat_o,
   input  logic [WB_DAT_WIDTH-1:0]   s_wb_dat_i,
   input  logic [WB_SEL_WIDTH-1:0]   s_wb_sel_i,
   input  logic                      s_wb_we_i,
   input  logic                      s_wb_stb_i,
   output logic                      s_wb_ack_o,

   output logic [7:0]                m_data,
   output logic                      m_valid,
   input  logic                      m_ready,

   output logic [FIFO_PTR_WIDTH:0]   fifo_count
);

   localparam logic [WAIT_CNT_WIDTH-1:0] CNT_ONE  = WAIT_CNT_WIDTH'(1);
   localparam logic [WAIT_CNT_WIDTH-1:0] CNT_LOAD = WAIT_CNT_WIDTH'(WAIT_CYCLES);

   logic [1:0]                state;
   logic [WAIT_CNT_WIDTH-1:0] wait_cnt;
   logic [1:0]                req_adr;
   logic [7:0]                req_dat;
   logic                      req_sel0;
   logic                      req_we;
   logic                      enable;

   logic                      fifo_empty;
   logic                      fifo_full;
   logic                      is_push;
   logic                      stall;
   logic                      commit;
   logic                      fifo_push;
   logic                      fifo_pop;
   logic                      fifo_flush;
   logic                      ctrl_write;
   logic [WB_DAT_WIDTH-1:0]   rdata;
   logic                      unused_bits;

   assign unused_bits = &{1'b0, s_wb_adr_i[WB_ADR_WIDTH-1:2],
                          s_wb_dat_i[WB_DAT_WIDTH-1:8], s_wb_sel_i[WB_SEL_WIDTH-1:1]};

   // A TX push against a full FIFO holds in COMMIT until a pop frees a slot.
   assign is_push    = req_we & req_sel0 & (req_adr == REG_TX_DATA);
   assign stall      = is_push & fifo_full;
   assign commit     = (state == ST_COMMIT) & s_wb_stb_i & cke & ~stall;
   assign ctrl_write = commit & req_we & (req_adr == REG_CONTROL);

   assign fifo_push  = commit & is_push;
   assign fifo_flush = ctrl_write & req_dat[CONTROL_FLUSH_BIT];
   assign fifo_pop   = m_valid & m_ready & cke;

   assign m_valid    = ~fifo_empty & enable;

   always_comb begin
      rdata = '0;
      case (req_adr)
         REG_STATUS: begin
            rdata[FIFO_PTR_WIDTH:0]  = fifo_count;
            rdata[STATUS_EMPTY_BIT]  = fifo_empty;
            rdata[STATUS_FULL_BIT]   = fifo_full;
         end
         REG_CONTROL: rdata[CONTROL_ENABLE_BIT] = enable;
         default: rdata = '0;
      endcase
   end

   assign s_wb_ack_o = commit;
   assign s_wb_dat_o = (commit && !req_we) ? rdata : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         wait_cnt <= '0;
         req_adr  <= '0;
         req_dat  <= '0;
         req_sel0 <= 1'b0;
         req_we   <= 1'b0;
         enable   <= INIT_ENABLE;
      end else if (cke) begin
         case (state)
            ST_IDLE: begin
               if (s_wb_stb_i) begin
                  req_adr  <= s_wb_adr_i[1:0];
                  req_dat  <= s_wb_dat_i[7:0];
                  req_sel0 <= s_wb_sel_i[0];
                  req_we   <= s_wb_we_i;
                  wait_cnt <= CNT_LOAD;
                  state    <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (!s_wb_stb_i) begin
                  state <= ST_IDLE;
               end else if (wait_cnt == '0) begin
                  state <= ST_COMMIT;
               end else begin
                  wait_cnt <= wait_cnt - CNT_ONE;
               end
            end
            ST_COMMIT: begin
               if (!s_wb_stb_i || !stall) begin
                  state <= ST_IDLE;
               end
               if (ctrl_write) begin
                  enable <= req_dat[CONTROL_ENABLE_BIT];
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   jelly2_wishbone_console_fifo #(
      .PTR_WIDTH  (FIFO_PTR_WIDTH),
      .DATA_WIDTH (8)
   ) u_fifo (
      .reset     (reset),
      .clk       (clk),
      .cke       (cke),
      .push      (fifo_push),
      .push_data (req_dat),
      .pop       (fifo_pop),
      .flush     (fifo_flush),
      .head      (m_data),
      .count     (fifo_count),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

endmodule

`default_nettype wire
